md5_crack_scheduler: RTL

MD5_CRACK_SCHEDULER -- requirements
Module: md5_crack_scheduler

---
 rtl/md5_sched_pkg.sv | 19 +
 rtl/ascii_dec_inc.sv | 29 ++
 rtl/md5_crack_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/md5_sched_pkg.sv
// Shared types and constants for the md5 crack scheduler and its ASCII incrementer.
package md5_sched_pkg;

  localparam int         DEFAULT_NUM_CORES = 4;
  localparam logic [7:0] ASCII_0           = 8'h30;
  localparam logic [7:0] ASCII_9           = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUSTED
  } sched_state_e;

endpackage

// File: rtl/ascii_dec_inc.sv
// Increments an 8-digit ASCII decimal number (MSD in [63:56]); wrap is set when
// "99999999" rolls over to "00000000".
module ascii_dec_inc
  import md5_sched_pkg::*;
(
  input  logic [63:0] msg_in,
  output logic [63:0] msg_out,
  output logic        wrap
);

  logic carry;

  always_comb begin
    carry   = 1'b1;
    msg_out = msg_in;
    for (int d = 0; d < 8; d++) begin
      if (carry) begin
        if (msg_in[d*8 +: 8] == ASCII_9) begin
          msg_out[d*8 +: 8] = ASCII_0;
        end else begin
          msg_out[d*8 +: 8] = msg_in[d*8 +: 8] + 8'd1;
          carry             = 1'b0;
        end
      end
    end
    wrap = carry;
  end

endmodule

// File: rtl/md5_crack_scheduler.sv
// Sequences a bank of md5 cores over an ASCII-decimal candidate range and
// reports the first cracked candidate or exhaustion of the range.
module md5_crack_scheduler
  import md5_sched_pkg::*;
#(
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int CLR_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [127:0]            passwd_hash,
  input  logic [63:0]             start_msg,
  input  logic [63:0]             end_msg,
  output logic                    core_reset_n,
  output logic [NUM_CORES-1:0]    core_enable,
  output logic [NUM_CORES*64-1:0] core_msg,
  output logic [127:0]            core_hash,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_cracked,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [63:0]             result_msg,
  output logic [31:0]             tested_cnt
);

  // state       | meaning
  // IDLE        | waiting for start
  // CLEAR       | core_reset_n held low for CLR_CYCLES cycles
  // LOAD        | one candidate per cycle into cores 0..NUM_CORES-1
  // FIRE        | one-cycle enable pulse to every valid core
  // WAIT        | collecting done/cracked from the valid cores
  // CHECK       | account the batch, pick found / exhausted / next batch
  // FOUND       | result_msg holds the cracked candidate
  // EXHAUSTED   | range finished without a hit

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  sched_state_e         state, next_state;
  logic [IDX_W-1:0]     load_idx, hit_idx;
  logic [CLR_W-1:0]     clr_cnt;
  logic [63:0]          cnt, cnt_inc, end_q;
  logic                 cnt_wrap, wrapped, last_ge_end;
  logic [63:0]          msg_q [NUM_CORES];
  logic [NUM_CORES-1:0] valid_q, done_q, hit_q, hit_v;
  logic [5:0]           valid_pop;
  logic [32:0]          tested_sum;
  logic                 accept, all_done;

  ascii_dec_inc u_inc (
    .msg_in  (cnt),
    .msg_out (cnt_inc),
    .wrap    (cnt_wrap)
  );

  assign accept   = start && (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED);
  assign hit_v    = hit_q & valid_q;
  assign all_done = ((done_q & valid_q) == valid_q);

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_msg
    assign core_msg[gi*64 +: 64] = msg_q[gi];
  end

  always_comb begin
    valid_pop = '0;
    for (int i = 0; i < NUM_CORES; i++) valid_pop = valid_pop + 6'(valid_q[i]);
  end

  assign tested_sum = {1'b0, tested_cnt} + 33'(valid_pop);

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_v[i]) hit_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      core_reset_n <= 1'b0;
    end else begin
      state        <= next_state;
      core_reset_n <= (next_state != S_CLEAR);
    end
  end

  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    found       = 1'b0;
    exhausted   = 1'b0;
    core_enable = '0;
    case (state)
      S_IDLE: begin
        if (accept) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == '0) next_state = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (load_idx == IDX_W'(NUM_CORES - 1)) next_state = S_FIRE;
      end
      S_FIRE: begin
        busy        = 1'b1;
        core_enable = valid_q;
        next_state  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (all_done) next_state = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (|hit_v)                      next_state = S_FOUND;
        else if (last_ge_end || wrapped) next_state = S_EXHAUSTED;
        else                             next_state = S_LOAD;
      end
      S_FOUND: begin
        found = 1'b1;
        if (accept) next_state = S_CLEAR;
      end
      S_EXHAUSTED: begin
        exhausted = 1'b1;
        if (accept) next_state = S_CLEAR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_hash   <= '0;
      end_q       <= '0;
      cnt         <= '0;
      wrapped     <= 1'b0;
      last_ge_end <= 1'b0;
      clr_cnt     <= '0;
      load_idx    <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      hit_q       <= '0;
      result_msg  <= '0;
      tested_cnt  <= '0;
      for (int i = 0; i < NUM_CORES; i++) msg_q[i] <= '0;
    end else begin
      if (accept) begin
        core_hash  <= passwd_hash;
        end_q      <= end_msg;
        cnt        <= start_msg;
        wrapped    <= 1'b0;
        tested_cnt <= '0;
        result_msg <= '0;
        clr_cnt    <= CLR_W'(CLR_CYCLES - 1);
      end
      case (state)
        S_CLEAR: begin
          if (clr_cnt != '0) clr_cnt <= clr_cnt - 1'b1;
          load_idx <= '0;
        end
        S_LOAD: begin
          msg_q[load_idx]   <= cnt;
          // once the counter has rolled past "99999999" nothing further is valid
          valid_q[load_idx] <= !wrapped && (cnt <= end_q);
          last_ge_end       <= (cnt >= end_q);
          cnt               <= cnt_inc;
          if (cnt_wrap) wrapped <= 1'b1;
          load_idx          <= load_idx + 1'b1;
        end
        S_FIRE: begin
          done_q <= '0;
          hit_q  <= '0;
        end
        S_WAIT: begin
          done_q <= done_q | core_done;
          hit_q  <= hit_q | (core_done & core_cracked);
        end
        S_CHECK: begin
          tested_cnt <= tested_sum[32] ? 32'hFFFF_FFFF : tested_sum[31:0];
          if (|hit_v) result_msg <= msg_q[hit_idx];
          load_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
